// File: rtl/walk_register.sv
// Sticky pedestrian walk-request latch with a one-cycle set strobe and a
// saturating diagnostic count of requests accepted since the last clear.
module walk_register #(
  parameter int EDGE_DETECT = 1,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             WR_Reset,
  input  logic             WR_Sync,
  output logic             WR,
  output logic             WR_Set,
  output logic [CNT_W-1:0] WR_Count
);

  logic             r_wr;
  logic             r_set;
  logic [CNT_W-1:0] r_cnt;
  logic             w_req;
  logic             w_cnt_max;

  generate
    if (EDGE_DETECT != 0) begin : g_edge
      // History clears with reset, so a level already high at release counts as an edge.
      logic r_sync_d;

      always_ff @(posedge clk or posedge WR_Reset) begin
        if (WR_Reset) begin
          r_sync_d <= 1'b0;
        end else begin
          r_sync_d <= WR_Sync;
        end
      end

      assign w_req = WR_Sync & ~r_sync_d;
    end else begin : g_level
      assign w_req = WR_Sync;
    end
  endgenerate

  assign w_cnt_max = &r_cnt;

  always_ff @(posedge clk or posedge WR_Reset) begin
    if (WR_Reset) begin
      r_wr  <= 1'b0;
      r_set <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr | w_req;
      r_set <= w_req & ~r_wr;
      if (w_req && !w_cnt_max) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign WR       = r_wr;
  assign WR_Set   = r_set;
  assign WR_Count = r_cnt;

endmodule

// File: tb/tb_walk_register.sv
// Bench for walk_register: edge-detect and level-detect instances share
// stimulus and are checked against a behavioural model and a vector table.
module tb_walk_register;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             WR_Reset;
  logic             WR_Sync;
  logic             wr1, set1, wr0, set0;
  logic [CNT_W-1:0] cnt1, cnt0;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: index 1 = edge-detect, index 0 = level-detect
  bit m_wr [2];
  bit m_set[2];
  int m_cnt[2];
  bit m_prev;

  typedef struct {
    logic s;
    logic wr1; logic set1; int cnt1;
    logic wr0; logic set0; int cnt0;
  } vec_t;

  vec_t tbl[7];

  walk_register #(.EDGE_DETECT(1), .CNT_W(CNT_W)) u_ed1 (
    .clk(clk), .WR_Reset(WR_Reset), .WR_Sync(WR_Sync),
    .WR(wr1), .WR_Set(set1), .WR_Count(cnt1)
  );

  walk_register #(.EDGE_DETECT(0), .CNT_W(CNT_W)) u_ed0 (
    .clk(clk), .WR_Reset(WR_Reset), .WR_Sync(WR_Sync),
    .WR(wr0), .WR_Set(set0), .WR_Count(cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int e = 0; e < 2; e++) begin
      m_wr[e]  = 1'b0;
      m_set[e] = 1'b0;
      m_cnt[e] = 0;
    end
    m_prev = 1'b0;
  endtask

  task automatic model_step(input bit s);
    bit req;
    for (int e = 0; e < 2; e++) begin
      req      = (e == 1) ? (s && !m_prev) : s;
      m_set[e] = req && !m_wr[e];
      if (req) m_wr[e] = 1'b1;
      if (req && m_cnt[e] < CMAX) m_cnt[e]++;
    end
    m_prev = s;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_wr_ed1"},  int'(wr1),  int'(m_wr[1]));
    chk({tag, "_set_ed1"}, int'(set1), int'(m_set[1]));
    chk({tag, "_cnt_ed1"}, int'(cnt1), m_cnt[1]);
    chk({tag, "_wr_ed0"},  int'(wr0),  int'(m_wr[0]));
    chk({tag, "_set_ed0"}, int'(set0), int'(m_set[0]));
    chk({tag, "_cnt_ed0"}, int'(cnt0), m_cnt[0]);
  endtask

  // One clock: drive WR_Sync, advance the model at the edge, sample 1 ns later
  task automatic cycle(input bit s, input string tag);
    WR_Sync = s;
    @(posedge clk);
    if (WR_Reset) model_clear();
    else model_step(s);
    #1;
    check_model(tag);
  endtask

  // Assert reset mid-cycle and confirm outputs clear before any clock edge
  task automatic async_reset(input string tag);
    #3;
    WR_Reset = 1'b1;
    #1;
    model_clear();
    check_model(tag);
  endtask

  task automatic release_reset();
    #1;
    WR_Reset = 1'b0;
  endtask

  initial begin
    int set_pulses;

    tbl[0] = '{s:0, wr1:0, set1:0, cnt1:0, wr0:0, set0:0, cnt0:0};
    tbl[1] = '{s:1, wr1:1, set1:1, cnt1:1, wr0:1, set0:1, cnt0:1};
    tbl[2] = '{s:0, wr1:1, set1:0, cnt1:1, wr0:1, set0:0, cnt0:1};
    tbl[3] = '{s:1, wr1:1, set1:0, cnt1:2, wr0:1, set0:0, cnt0:2};
    tbl[4] = '{s:1, wr1:1, set1:0, cnt1:2, wr0:1, set0:0, cnt0:3};
    tbl[5] = '{s:0, wr1:1, set1:0, cnt1:2, wr0:1, set0:0, cnt0:3};
    tbl[6] = '{s:1, wr1:1, set1:0, cnt1:3, wr0:1, set0:0, cnt0:4};

    // Reset and idle
    WR_Reset = 1'b1;
    WR_Sync  = 1'b0;
    model_clear();
    #12;
    check_model("reset_hold");
    #8;
    WR_Reset = 1'b0;
    for (int i = 0; i < 8; i++) cycle(1'b0, "idle");

    // Single request, then WR held for 500 ns
    cycle(1'b1, "single_req");
    chk("single_wr_ed1", int'(wr1), 1);
    chk("single_set_ed1", int'(set1), 1);
    cycle(1'b0, "single_after");
    chk("single_set_clear_ed1", int'(set1), 0);
    for (int i = 0; i < 50; i++) cycle(1'b0, "single_hold");
    chk("single_hold_wr_ed1", int'(wr1), 1);
    chk("single_hold_cnt_ed1", int'(cnt1), 1);

    // Asynchronous clear, then a fresh request is captured
    async_reset("clear_async");
    chk("clear_wr_ed1", int'(wr1), 0);
    chk("clear_cnt_ed1", int'(cnt1), 0);
    release_reset();
    cycle(1'b0, "clear_idle");
    cycle(1'b1, "clear_req");
    cycle(1'b0, "clear_req_low");
    chk("clear_rewr_ed1", int'(wr1), 1);

    // Vector table from a clean state
    async_reset("tbl_reset");
    release_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].s, "tbl_model");
      chk($sformatf("tbl%0d_wr_ed1", i),  int'(wr1),  int'(tbl[i].wr1));
      chk($sformatf("tbl%0d_set_ed1", i), int'(set1), int'(tbl[i].set1));
      chk($sformatf("tbl%0d_cnt_ed1", i), int'(cnt1), tbl[i].cnt1);
      chk($sformatf("tbl%0d_wr_ed0", i),  int'(wr0),  int'(tbl[i].wr0));
      chk($sformatf("tbl%0d_set_ed0", i), int'(set0), int'(tbl[i].set0));
      chk($sformatf("tbl%0d_cnt_ed0", i), int'(cnt0), tbl[i].cnt0);
    end

    // Three separate pulses: count 3, strobe once
    async_reset("pulses_reset");
    release_reset();
    cycle(1'b0, "pulses_idle");
    set_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, "pulses_hi");
      if (set1) set_pulses++;
      cycle(1'b0, "pulses_lo");
      if (set1) set_pulses++;
    end
    chk("pulses_cnt_ed1", int'(cnt1), 3);
    chk("pulses_strobes_ed1", set_pulses, 1);

    // Held high 20 cycles: edge mode +1, level mode saturates
    async_reset("held_reset");
    release_reset();
    cycle(1'b0, "held_idle");
    for (int i = 0; i < 20; i++) cycle(1'b1, "held");
    chk("held_cnt_ed1", int'(cnt1), 1);
    chk("held_cnt_ed0", int'(cnt0), CMAX);
    chk("held_wr_ed0", int'(wr0), 1);
    for (int i = 0; i < 3; i++) cycle(1'b1, "held_sat");
    chk("held_sat_cnt_ed0", int'(cnt0), CMAX);

    // Reset held across an edge with WR_Sync high: request lost
    async_reset("simul_reset");
    cycle(1'b1, "simul_edge");
    chk("simul_wr_ed1", int'(wr1), 0);
    chk("simul_cnt_ed0", int'(cnt0), 0);
    release_reset();
    cycle(1'b1, "simul_release");
    chk("simul_rel_wr_ed1", int'(wr1), 1);
    chk("simul_rel_cnt_ed1", int'(cnt1), 1);

    // Randomised traffic with occasional mid-cycle clears
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        async_reset("rand_reset");
        if ($urandom_range(0, 1) == 1) cycle(1'($urandom_range(0, 1)), "rand_in_reset");
        release_reset();
      end
      cycle(1'($urandom_range(0, 2) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/walk_register.md
Name: walk_register

Overview:
- Sticky latch for pedestrian walk requests in the traffic light controller.
- Captures a synchronized push-button request (WR_Sync) and holds WR high until the controller FSM clears it with WR_Reset after serving the walk phase.
- Also provides a one-cycle set strobe and a saturating count of requests seen since the last clear, for diagnostics.

Parameters:
- EDGE_DETECT, 1, 1 = a request is a rising edge of WR_Sync; 0 = any cycle with WR_Sync high is a request.
- CNT_W, 4, width of WR_Count; must be at least 1.

Ports:
- clk, input, 1, single system clock; all state updates on the rising edge.
- WR_Reset, input, 1, asynchronous active-high reset/clear of all state; also used by the FSM as the functional clear.
- WR_Sync, input, 1, walk request already synchronized to clk by the upstream debouncer/synchronizer.
- WR, output, 1, registered walk-request flag; high while a request is pending.
- WR_Set, output, 1, registered one-cycle strobe; high in the cycle WR first goes 0 to 1.
- WR_Count, output, CNT_W, registered saturating count of accepted requests since the last reset.

Behaviour:
- Reset: WR_Reset is asynchronous and active-high.
  - While WR_Reset=1: WR=0, WR_Set=0, WR_Count=0, edge-detect history register=0, regardless of clk.
  - On deassertion, the first rising clk edge samples normally.
- Request detection:
  - EDGE_DETECT=1: req = WR_Sync & ~WR_Sync_d, where WR_Sync_d is WR_Sync registered on clk.
  - EDGE_DETECT=0: req = WR_Sync.
- WR: on each rising clk edge with WR_Reset=0, WR <= WR | req.
  - Once set, WR stays 1 until WR_Reset; there is no other clear path.
- Latency: WR_Sync is high across edge N, so WR=1 after edge N (1-cycle latency).
- WR_Set: <= req & ~WR.
  - High for exactly one cycle, coincident with the cycle WR becomes 1.
  - Further requests while WR=1 produce no strobe.
- WR_Count: <= WR_Count + 1 on every accepted req, including while WR=1.
  - Saturates at 2^CNT_W-1; no wrap-around.
- Simultaneous WR_Reset=1 and a request: reset wins. All outputs are 0 and the request is lost.
- Reset mid-operation:
  - WR_Reset asserted asynchronously between edges clears outputs immediately.
  - A request must be re-presented after release to be captured.
- WR_Sync held high continuously:
  - EDGE_DETECT=1 gives one request.
  - EDGE_DETECT=0 counts every cycle, saturating.
- WR_Sync high out of reset with EDGE_DETECT=1: counts as a rising edge at the first sampled edge, because the history register resets to 0.
- Sub-cycle WR_Sync pulses that do not span a rising clk edge are not captured. The upstream block guarantees at least a one-cycle pulse.
- Outputs are glitch-free registers. No combinational path from inputs to outputs except the asynchronous reset.

Test Plan:
- Reset/idle (clk 10 ns): WR_Reset=1 for 20 ns, then 0, WR_Sync=0 for 100 ns -> WR=0, WR_Set=0, WR_Count=0 throughout.
- Single request: at t=100 ns drive WR_Sync=1 for one clock, then 0.
  - WR=1 and WR_Set=1 after the next rising edge; WR_Set=0 one cycle later.
  - WR stays 1 for the following 500 ns; WR_Count=1.
- Clear: after the previous case, assert WR_Reset=1 mid-cycle -> WR=0 and WR_Count=0 immediately, before the next clk edge. Release, then pulse WR_Sync -> WR=1 again.
- Repeated and held requests, EDGE_DETECT=1:
  - Three separate 1-cycle pulses -> WR_Count=3, WR_Set pulses once only.
  - WR_Sync held high 20 cycles -> WR_Count increments by exactly 1.
- Saturation, EDGE_DETECT=0, CNT_W=4: WR_Sync held high 20 cycles -> WR_Count reaches 15 and stays 15; WR=1.
- Simultaneous: WR_Reset=1 while WR_Sync=1 over a clock edge -> WR=0, WR_Count=0. After WR_Reset falls, WR_Sync still high, EDGE_DETECT=1 -> WR=1 at the next edge.
